// File: rtl/fwd_tracker.sv
// fwd_tracker: per-channel writeback shift buffers with youngest-match operand bypass select and stall.
// Defining FWD_TRACKER_PERF_EN adds saturating hit/stall counters (o_hit_cnt, o_stall_cnt).
module fwd_tracker #(
  parameter int NUM_CH      = 3,
  parameter int DEPTH       = 3,
  parameter int NUM_SRC     = 4,
  parameter int ADDR_W      = 5,
  parameter int READY_STAGE = 1
`ifdef FWD_TRACKER_PERF_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_adv,
  input  logic                            i_flush,
  input  logic [NUM_CH-1:0]               i_ch_valid,
  input  logic [NUM_CH*ADDR_W-1:0]        i_ch_rd,
  input  logic [NUM_CH-1:0]               i_ch_rdy,
  input  logic [NUM_SRC*ADDR_W-1:0]       i_src_addr,
  input  logic [NUM_SRC-1:0]              i_src_req,
  output logic [NUM_SRC*NUM_CH*DEPTH-1:0] o_fwd_sel,
  output logic [NUM_SRC-1:0]              o_fwd_hit,
  output logic                            o_stall
`ifdef FWD_TRACKER_PERF_EN
  ,
  output logic [CNT_W-1:0]                o_hit_cnt,
  output logic [CNT_W-1:0]                o_stall_cnt
`endif
);
  localparam int NE = NUM_CH * DEPTH;

  logic [NE-1:0]             valid_reg, valid_next;
  logic [NE-1:0]             rdy_reg, rdy_next;
  logic [NE-1:0][ADDR_W-1:0] rd_reg, rd_next;
  logic [NUM_SRC-1:0]        src_stall;
  logic                      shift_en;

  assign shift_en = i_adv & ~i_flush;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      for (gj = 0; gj < DEPTH; gj++) begin : g_stage
        localparam int   IDX       = gi * DEPTH + gj;
        localparam logic FORCE_RDY = (gj >= READY_STAGE);
        logic              valid_in;
        logic              rdy_in;
        logic [ADDR_W-1:0] rd_in;

        if (gj == 0) begin : g_head
          assign valid_in = i_ch_valid[gi];
          assign rd_in    = i_ch_rd[gi*ADDR_W +: ADDR_W];
          assign rdy_in   = i_ch_rdy[gi];
        end else begin : g_tail
          assign valid_in = valid_reg[IDX-1];
          assign rd_in    = rd_reg[IDX-1];
          assign rdy_in   = rdy_reg[IDX-1];
        end

        // Entries landing at or past READY_STAGE have their data guaranteed.
        assign valid_next[IDX] = i_flush ? 1'b0 : (shift_en ? valid_in : valid_reg[IDX]);
        assign rd_next[IDX]    = shift_en ? rd_in : rd_reg[IDX];
        assign rdy_next[IDX]   = shift_en ? (rdy_in | FORCE_RDY) : rdy_reg[IDX];
      end
    end

    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [ADDR_W-1:0] addr;
      logic [NE-1:0]     sel;
      logic              sel_rdy;
      logic              found;

      assign addr = i_src_addr[gi*ADDR_W +: ADDR_W];

      // Scan youngest stage first, lowest channel first within a stage.
      always_comb begin
        sel     = '0;
        sel_rdy = 1'b0;
        found   = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (!found && valid_reg[c*DEPTH+s] && (rd_reg[c*DEPTH+s] == addr) && (addr != '0)) begin
              sel[c*DEPTH+s] = 1'b1;
              sel_rdy        = rdy_reg[c*DEPTH+s];
              found          = 1'b1;
            end
          end
        end
      end

      assign o_fwd_sel[gi*NE +: NE] = sel;
      assign o_fwd_hit[gi]          = found;
      assign src_stall[gi]          = i_src_req[gi] & found & ~sel_rdy;
    end
  endgenerate

  assign o_stall = |src_stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_reg <= '0;
      rdy_reg   <= '0;
      rd_reg    <= '0;
    end else begin
      valid_reg <= valid_next;
      rdy_reg   <= rdy_next;
      rd_reg    <= rd_next;
    end
  end

`ifdef FWD_TRACKER_PERF_EN
  logic [CNT_W-1:0] hit_cnt_reg;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             any_hit;

  assign any_hit = |(i_src_req & o_fwd_hit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hit_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (o_stall && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (any_hit && !o_stall && (hit_cnt_reg != '1))
        hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
    end
  end

  assign o_hit_cnt   = hit_cnt_reg;
  assign o_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fwd_tracker.sv
// Bench for fwd_tracker: hand-written vector table, reset corner sequence and random run vs a reference model.
module tb_fwd_tracker;
  localparam int NUM_CH      = 3;
  localparam int DEPTH       = 3;
  localparam int NUM_SRC     = 4;
  localparam int ADDR_W      = 5;
  localparam int READY_STAGE = 1;
  localparam int NE          = NUM_CH * DEPTH;
  localparam int SW          = NUM_SRC * NE;

  logic                       i_clk = 1'b0;
  logic                       i_rst_n = 1'b1;
  logic                       i_adv = 1'b0;
  logic                       i_flush = 1'b0;
  logic [NUM_CH-1:0]          i_ch_valid = '0;
  logic [NUM_CH*ADDR_W-1:0]   i_ch_rd = '0;
  logic [NUM_CH-1:0]          i_ch_rdy = '0;
  logic [NUM_SRC*ADDR_W-1:0]  i_src_addr = '0;
  logic [NUM_SRC-1:0]         i_src_req = '0;
  logic [SW-1:0]              o_fwd_sel;
  logic [NUM_SRC-1:0]         o_fwd_hit;
  logic                       o_stall;
`ifdef FWD_TRACKER_PERF_EN
  logic [31:0]                o_hit_cnt;
  logic [31:0]                o_stall_cnt;
`endif

  fwd_tracker #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .NUM_SRC(NUM_SRC),
    .ADDR_W(ADDR_W), .READY_STAGE(READY_STAGE)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_adv(i_adv), .i_flush(i_flush),
    .i_ch_valid(i_ch_valid), .i_ch_rd(i_ch_rd), .i_ch_rdy(i_ch_rdy),
    .i_src_addr(i_src_addr), .i_src_req(i_src_req),
    .o_fwd_sel(o_fwd_sel), .o_fwd_hit(o_fwd_hit), .o_stall(o_stall)
`ifdef FWD_TRACKER_PERF_EN
    , .o_hit_cnt(o_hit_cnt), .o_stall_cnt(o_stall_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Reference model: buffer contents plus an oldest-to-youngest scan where the last match wins.
  bit                 m_valid [NE];
  bit                 m_rdy   [NE];
  logic [ADDR_W-1:0]  m_rd    [NE];
  logic [SW-1:0]      m_sel;
  logic [NUM_SRC-1:0] m_hit;
  logic               m_stall;
  logic [ADDR_W-1:0]  m_a;
  int                 m_loc;
  int unsigned        tally_hit, tally_stall;

  always_comb begin
    m_sel   = '0;
    m_hit   = '0;
    m_stall = 1'b0;
    m_a     = '0;
    m_loc   = -1;
    for (int k = 0; k < NUM_SRC; k++) begin
      m_a   = i_src_addr[k*ADDR_W +: ADDR_W];
      m_loc = -1;
      for (int s = DEPTH-1; s >= 0; s--)
        for (int c = NUM_CH-1; c >= 0; c--)
          if (m_a != '0 && m_valid[c*DEPTH+s] && m_rd[c*DEPTH+s] == m_a)
            m_loc = c*DEPTH + s;
      if (m_loc >= 0) begin
        m_sel[k*NE + m_loc] = 1'b1;
        m_hit[k] = 1'b1;
        if (i_src_req[k] && !m_rdy[m_loc]) m_stall = 1'b1;
      end
    end
  end

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NE; i++) begin
        m_valid[i] <= 1'b0;
        m_rdy[i]   <= 1'b0;
        m_rd[i]    <= '0;
      end
      tally_hit   <= 0;
      tally_stall <= 0;
    end else begin
      if (m_stall) tally_stall <= tally_stall + 1;
      else if (|(m_hit & i_src_req)) tally_hit <= tally_hit + 1;
      if (i_flush) begin
        for (int i = 0; i < NE; i++) m_valid[i] <= 1'b0;
      end else if (i_adv) begin
        for (int c = 0; c < NUM_CH; c++) begin
          for (int s = 0; s < DEPTH; s++) begin
            if (s == 0) begin
              m_valid[c*DEPTH] <= i_ch_valid[c];
              m_rd[c*DEPTH]    <= i_ch_rd[c*ADDR_W +: ADDR_W];
              m_rdy[c*DEPTH]   <= (READY_STAGE <= 0) ? 1'b1 : i_ch_rdy[c];
            end else begin
              m_valid[c*DEPTH+s] <= m_valid[c*DEPTH+s-1];
              m_rd[c*DEPTH+s]    <= m_rd[c*DEPTH+s-1];
              m_rdy[c*DEPTH+s]   <= (s >= READY_STAGE) ? 1'b1 : m_rdy[c*DEPTH+s-1];
            end
          end
        end
      end
    end
  end

  typedef struct {
    string              name;
    logic [SW-1:0]      sel;
    logic [NUM_SRC-1:0] hit;
    logic               stall;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        adv;
    logic        flush;
    logic [2:0]  cv;
    logic [14:0] crd;
    logic [2:0]  crdy;
    logic [4:0]  src0;
    logic [3:0]  req;
    logic [8:0]  e_sel0;
    logic        e_hit0;
    logic        e_stall;
  } vec_t;
  vec_t vt [25];

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic vec_t mk(input logic adv, input logic fl, input logic [2:0] cv,
                              input logic [4:0] r2, input logic [4:0] r1, input logic [4:0] r0,
                              input logic [2:0] rdy, input logic [4:0] src, input logic [3:0] req,
                              input logic [8:0] es, input logic eh, input logic est);
    vec_t v;
    v.adv = adv; v.flush = fl; v.cv = cv; v.crd = {r2, r1, r0}; v.crdy = rdy;
    v.src0 = src; v.req = req; v.e_sel0 = es; v.e_hit0 = eh; v.e_stall = est;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic drive(input logic adv, input logic fl, input logic [2:0] cv, input logic [14:0] crd,
                       input logic [2:0] crdy, input logic [19:0] saddr, input logic [3:0] req);
    i_adv = adv; i_flush = fl; i_ch_valid = cv; i_ch_rd = crd; i_ch_rdy = crdy;
    i_src_addr = saddr; i_src_req = req;
  endtask

  // Called just after a rising edge with inputs driven; compares at the falling edge, returns at next rise+1.
  task automatic run_cycle(input string nm, output logic [SW-1:0] a_sel,
                           output logic [NUM_SRC-1:0] a_hit, output logic a_stall);
    exp_t e;
    #1;
    e.name = nm; e.sel = m_sel; e.hit = m_hit; e.stall = m_stall;
    sb_q.push_back(e);
    @(negedge i_clk);
    e = sb_q.pop_front();
    a_sel = o_fwd_sel; a_hit = o_fwd_hit; a_stall = o_stall;
    chk({e.name, " sel"}, 64'(a_sel), 64'(e.sel));
    chk({e.name, " hit"}, 64'(a_hit), 64'(e.hit));
    chk({e.name, " stall"}, 64'(a_stall), 64'(e.stall));
    $display("[%0t] %s adv=%b flush=%b sel=%h hit=%b stall=%b", $time, nm, i_adv, i_flush, a_sel, a_hit, a_stall);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [SW-1:0]      a_sel;
    logic [NUM_SRC-1:0] a_hit;
    logic               a_stall;
    logic [8:0]         sel0;

    vt[0]  = mk(1,0,3'b001, 0, 0, 7, 3'b001,  7,4'b0001, 9'h000,0,0);
    vt[1]  = mk(1,0,3'b010, 0, 7, 0, 3'b010,  7,4'b0001, 9'h001,1,0);
    vt[2]  = mk(0,0,3'b000, 0, 0, 0, 3'b000,  7,4'b0001, 9'h008,1,0);
    vt[3]  = mk(1,1,3'b111, 7, 7, 7, 3'b111,  7,4'b0001, 9'h008,1,0);
    vt[4]  = mk(1,0,3'b101, 9, 0, 9, 3'b101,  7,4'b0001, 9'h000,0,0);
    vt[5]  = mk(0,0,3'b000, 0, 0, 0, 3'b000,  9,4'b0001, 9'h001,1,0);
    vt[6]  = mk(0,1,3'b000, 0, 0, 0, 3'b000,  9,4'b0001, 9'h001,1,0);
    vt[7]  = mk(1,0,3'b100,12, 0, 0, 3'b000, 12,4'b0001, 9'h000,0,0);
    vt[8]  = mk(0,0,3'b001, 0, 0,12, 3'b001, 12,4'b0001, 9'h040,1,1);
    vt[9]  = mk(0,0,3'b001, 0, 0,12, 3'b001, 12,4'b0001, 9'h040,1,1);
    vt[10] = mk(0,0,3'b001, 0, 0,12, 3'b001, 12,4'b0001, 9'h040,1,1);
    vt[11] = mk(0,0,3'b000, 0, 0, 0, 3'b000, 12,4'b0000, 9'h040,1,0);
    vt[12] = mk(1,0,3'b000, 0, 0, 0, 3'b000, 12,4'b0001, 9'h040,1,1);
    vt[13] = mk(0,0,3'b000, 0, 0, 0, 3'b000, 12,4'b0001, 9'h080,1,0);
    vt[14] = mk(1,0,3'b001, 0, 0, 0, 3'b001, 12,4'b0001, 9'h080,1,0);
    vt[15] = mk(0,0,3'b000, 0, 0, 0, 3'b000,  0,4'b0001, 9'h000,0,0);
    vt[16] = mk(0,0,3'b000, 0, 0, 0, 3'b000, 12,4'b0001, 9'h100,1,0);
    vt[17] = mk(1,0,3'b010, 0, 3, 0, 3'b010,  3,4'b0001, 9'h000,0,0);
    vt[18] = mk(1,1,3'b000, 0, 0, 0, 3'b000,  3,4'b0001, 9'h008,1,0);
    vt[19] = mk(0,0,3'b000, 0, 0, 0, 3'b000,  3,4'b0001, 9'h000,0,0);
    vt[20] = mk(1,0,3'b001, 0, 0, 4, 3'b001,  4,4'b0001, 9'h000,0,0);
    vt[21] = mk(1,0,3'b010, 0, 4, 0, 3'b000,  4,4'b0001, 9'h001,1,0);
    vt[22] = mk(0,0,3'b000, 0, 0, 0, 3'b000,  4,4'b0001, 9'h008,1,1);
    vt[23] = mk(1,0,3'b000, 0, 0, 0, 3'b000,  4,4'b0001, 9'h008,1,1);
    vt[24] = mk(0,0,3'b000, 0, 0, 0, 3'b000,  4,4'b0001, 9'h010,1,0);

    // Power-on reset
    #2 i_rst_n = 1'b0;
    #1;
    chk("reset sel", 64'(o_fwd_sel), 64'd0);
    chk("reset hit", 64'(o_fwd_hit), 64'd0);
    chk("reset stall", 64'(o_stall), 64'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Directed vector table
    for (int i = 0; i < 25; i++) begin
      drive(vt[i].adv, vt[i].flush, vt[i].cv, vt[i].crd, vt[i].crdy, {15'd0, vt[i].src0}, vt[i].req);
      run_cycle($sformatf("vec%0d", i), a_sel, a_hit, a_stall);
      sel0 = a_sel[8:0];
      chk($sformatf("vec%0d sel0", i), 64'(sel0), 64'(vt[i].e_sel0));
      chk($sformatf("vec%0d hitv", i), 64'(a_hit), 64'({3'b000, vt[i].e_hit0}));
      chk($sformatf("vec%0d stallv", i), 64'(a_stall), 64'(vt[i].e_stall));
    end

    // Asynchronous reset with full buffers, youngest producer not ready
    drive(1,0,3'b111,{5'd5,5'd5,5'd5},3'b111,20'd5,4'b0001);
    run_cycle("fill0", a_sel, a_hit, a_stall);
    run_cycle("fill1", a_sel, a_hit, a_stall);
    drive(1,0,3'b111,{5'd5,5'd5,5'd5},3'b000,20'd5,4'b0001);
    run_cycle("fill2", a_sel, a_hit, a_stall);
    drive(0,0,3'b000,15'd0,3'b000,20'd5,4'b0001);
    run_cycle("full", a_sel, a_hit, a_stall);
    chk("pre-reset stall", 64'(a_stall), 64'd1);
    #1 i_rst_n = 1'b0;
    #1;
    chk("async rst sel", 64'(o_fwd_sel), 64'd0);
    chk("async rst hit", 64'(o_fwd_hit), 64'd0);
    chk("async rst stall", 64'(o_stall), 64'd0);
`ifdef FWD_TRACKER_PERF_EN
    chk("async rst hit_cnt", 64'(o_hit_cnt), 64'd0);
    chk("async rst stall_cnt", 64'(o_stall_cnt), 64'd0);
`endif
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    run_cycle("post-rst", a_sel, a_hit, a_stall);
    chk("post-rst hit src5", 64'(a_hit), 64'd0);
    drive(1,0,3'b010,{5'd0,5'd5,5'd0},3'b010,20'd5,4'b0001);
    run_cycle("post-rst insert", a_sel, a_hit, a_stall);
    drive(0,0,3'b000,15'd0,3'b000,20'd5,4'b0001);
    run_cycle("post-rst lookup", a_sel, a_hit, a_stall);
    sel0 = a_sel[8:0];
    chk("post-rst sel0", 64'(sel0), 64'h008);

    // Random traffic against the model
    for (int n = 0; n < 1000; n++) begin
      i_adv   = ($urandom_range(0, 3) != 0);
      i_flush = ($urandom_range(0, 19) == 0);
      i_ch_valid = NUM_CH'($urandom);
      i_ch_rdy   = NUM_CH'($urandom);
      for (int c = 0; c < NUM_CH; c++) i_ch_rd[c*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
      for (int k = 0; k < NUM_SRC; k++) i_src_addr[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
      i_src_req = NUM_SRC'($urandom);
      run_cycle($sformatf("rnd%0d", n), a_sel, a_hit, a_stall);
    end

    @(negedge i_clk);
`ifdef FWD_TRACKER_PERF_EN
    chk("hit_cnt", 64'(o_hit_cnt), 64'(tally_hit));
    chk("stall_cnt", 64'(o_stall_cnt), 64'(tally_stall));
    $display("[%0t] perf hit_cnt=%0d stall_cnt=%0d", $time, o_hit_cnt, o_stall_cnt);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
